// File: rtl/axon_pkg.sv
// Shared definitions for the AXON BRAM write/read address sequencers.
package axon_pkg;

    localparam int DW_DEFAULT             = 16;
    localparam int ADDRESS_LENGTH_DEFAULT = 13;
    localparam int FLAG_PERIOD            = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

    // A zero or oversized request means "a full block".
    function automatic int effective_len(input int len, input int max_count);
        return ((len == 0) || (len > max_count)) ? max_count : len;
    endfunction

endpackage

// File: rtl/axon_len_counter.sv
// Block word counter: effective length latch, post-increment flag and last-word compare.
module axon_len_counter
    import axon_pkg::*;
#(
    parameter int MAX_COUNT = 512,
    parameter int CW        = $clog2(MAX_COUNT) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] len_i,
    input  logic          inc_i,
    output logic [CW-1:0] count_o,
    output logic          last_o,
    output logic          flag_o
);

    localparam int FW = $clog2(FLAG_PERIOD);

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] eff_len_q, eff_len_d;
    logic [CW-1:0] count_inc;

    assign count_inc = count_q + CW'(1);

    always_comb begin
        count_d   = count_q;
        eff_len_d = eff_len_q;
        if (load_i) begin
            count_d   = '0;
            eff_len_d = CW'(effective_len(int'(len_i), MAX_COUNT));
        end else if (inc_i) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            eff_len_q <= '0;
        end else begin
            count_q   <= count_d;
            eff_len_q <= eff_len_d;
        end
    end

    // Flags describe the word being accepted now, i.e. the post-increment count.
    assign count_o = count_q;
    assign last_o  = (count_inc == eff_len_q);
    assign flag_o  = (count_inc[FW-1:0] == '0);

endmodule

// File: rtl/axon_bram_writer.sv
// Valid/ready word stream to BRAM port A block writer, with 1-per-16 and done pulses.
// Optional WRITER_CHECKSUM_EN adds a per-block modulo-2^DW sum of committed words.
module axon_bram_writer
    import axon_pkg::*;
#(
    parameter int  DW             = DW_DEFAULT,
    parameter int  ADDRESS_LENGTH = ADDRESS_LENGTH_DEFAULT,
    parameter int  MAX_COUNT      = 512,
    localparam int CW             = $clog2(MAX_COUNT) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDRESS_LENGTH-1:0] base_addr,
    input  logic [CW-1:0]             len,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DW-1:0]             s_data,
    output logic                      ena,
    output logic                      wea,
    output logic [ADDRESS_LENGTH-1:0] addra,
    output logic [DW-1:0]             dia,
    output logic                      flag_1per16,
    output logic                      busy,
`ifdef WRITER_CHECKSUM_EN
    output logic [DW-1:0]             checksum,
`endif
    output logic                      done
);

    wr_state_e state_q, state_d;

    logic                      accept_start;
    logic                      hs;
    logic                      last_w;
    logic                      flag_w;
    logic [CW-1:0]             count_w;
    logic [ADDRESS_LENGTH-1:0] base_q, base_d;
    logic [ADDRESS_LENGTH-1:0] addra_q, addra_d;
    logic [DW-1:0]             dia_q, dia_d;
    logic                      wr_q;
    logic                      flag_q;
    logic                      done_q;

    assign s_ready = (state_q == ST_WRITE);
    assign busy    = (state_q == ST_WRITE);
    assign hs      = s_valid & s_ready;

    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_WRITE;
                    accept_start = 1'b1;
                end
            end
            ST_WRITE: begin
                if (hs && last_w) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    axon_len_counter #(
        .MAX_COUNT (MAX_COUNT),
        .CW        (CW)
    ) u_len_counter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept_start),
        .len_i   (len),
        .inc_i   (hs),
        .count_o (count_w),
        .last_o  (last_w),
        .flag_o  (flag_w)
    );

    // Address wraps naturally at 2^ADDRESS_LENGTH.
    always_comb begin
        base_d  = accept_start ? base_addr : base_q;
        addra_d = hs ? (base_q + ADDRESS_LENGTH'(count_w)) : addra_q;
        dia_d   = hs ? s_data : dia_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            addra_q <= '0;
            dia_q   <= '0;
            wr_q    <= 1'b0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addra_q <= addra_d;
            dia_q   <= dia_d;
            wr_q    <= hs;
            flag_q  <= hs & flag_w;
            done_q  <= hs & last_w;
        end
    end

    assign ena         = wr_q;
    assign wea         = wr_q;
    assign addra       = addra_q;
    assign dia         = dia_q;
    assign flag_1per16 = flag_q;
    assign done        = done_q;

`ifdef WRITER_CHECKSUM_EN
    logic [DW-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (accept_start) begin
            sum_d = '0;
        end else if (hs) begin
            sum_d = sum_q + s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_axon_bram_writer.sv
// Randomized self-checking bench for axon_bram_writer against a block-level write model.
module tb_axon_bram_writer;

    localparam int DW   = 16;
    localparam int AL   = 13;
    localparam int MAXC = 512;
    localparam int CW   = $clog2(MAXC) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AL-1:0] base_addr;
    logic [CW-1:0] len;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          ena;
    logic          wea;
    logic [AL-1:0] addra;
    logic [DW-1:0] dia;
    logic          flag_1per16;
    logic          busy;
    logic          done;
`ifdef WRITER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [AL-1:0] exp_addra;
    logic [DW-1:0] exp_dia;
    logic [DW-1:0] bram [0:(1<<AL)-1];

    always #5 clk = ~clk;

    axon_bram_writer #(
        .DW             (DW),
        .ADDRESS_LENGTH (AL),
        .MAX_COUNT      (MAXC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .len         (len),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .ena         (ena),
        .wea         (wea),
        .addra       (addra),
        .dia         (dia),
        .flag_1per16 (flag_1per16),
        .busy        (busy),
`ifdef WRITER_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .done        (done)
    );

    // Port A side of the BRAM, used for readback after each block.
    always @(posedge clk) begin
        if (ena && wea) bram[addra] <= dia;
    end

    // Runs one block: vmode 0 = valid held, 1 = valid every other cycle, 2 = random valid.
    task automatic run_block(input logic [AL-1:0] base, input int len_in, input int vmode,
                             input bit seq_words, input bit poke_start, input int abort_at,
                             input string name);
        int            eff;
        logic [DW-1:0] words[$];
        int            k;
        int            cyc;
        bit            pend;
        bit            rdy;
        logic [DW-1:0] sum;
        logic [3:0]    exp_ctl;
        eff = (len_in == 0 || len_in > MAXC) ? MAXC : len_in;
        sum = '0;
        for (int i = 0; i < eff; i++) begin
            words.push_back(seq_words ? DW'(i + 1) : DW'($urandom));
            sum = sum + words[i];
        end

        @(negedge clk);
        start = 1'b1; base_addr = base; len = CW'(len_in); s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
`ifdef WRITER_CHECKSUM_EN
        n_cmp++;
        if (checksum !== '0) begin
            n_err++; $display("FAIL %s checksum_clear: got %0d want 0", name, checksum);
        end
`endif

        k = 0; pend = 1'b0; cyc = 0;
        forever begin
            start = 1'b0;
            if (pend) begin
                exp_addra = base + AL'(k - 1);
                exp_dia   = words[k-1];
                exp_ctl   = {1'b1, 1'b1, (k % 16 == 0), (k == eff)};
            end else begin
                exp_ctl = 4'b0000;
            end
            n_cmp++;
            if ({ena, wea, flag_1per16, done} !== exp_ctl) begin
                n_err++;
                $display("FAIL %s ctl word%0d: ena/wea/flag/done=%b want %b", name, k,
                         {ena, wea, flag_1per16, done}, exp_ctl);
            end
            n_cmp++;
            if (addra !== exp_addra || dia !== exp_dia) begin
                n_err++;
                $display("FAIL %s addr/data word%0d: got %0d/%h want %0d/%h", name, k,
                         addra, dia, exp_addra, exp_dia);
            end
            rdy = (k < eff);
            n_cmp++;
            if (s_ready !== rdy || busy !== rdy) begin
                n_err++;
                $display("FAIL %s ready/busy word%0d: got %b/%b want %b", name, k,
                         s_ready, busy, rdy);
            end
            if (pend && k == eff) break;
            if (abort_at > 0 && k == abort_at) begin
                s_valid = 1'b0;
                return;
            end
            if (cyc > 4 * eff + 50) begin
                n_err++;
                $display("FAIL %s timeout: got %0d words want %0d", name, k, eff);
                break;
            end
            case (vmode)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = (k < eff) ? words[k] : DW'($urandom);
            if (poke_start && (k == eff / 2 || k == eff - 1)) begin
                start = 1'b1; base_addr = ~base; len = CW'(3);
            end
            pend = s_valid && rdy;
            if (pend) k++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; s_valid = 1'b0;

        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || wea !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s post_done_idle: ready/busy/wea/done=%b%b%b%b want 0000", name,
                     s_ready, busy, wea, done);
        end
`ifdef WRITER_CHECKSUM_EN
        n_cmp++;
        if (checksum !== sum) begin
            n_err++; $display("FAIL %s checksum: got %0d want %0d", name, checksum, sum);
        end
`endif
        for (int i = 0; i < eff; i++) begin
            n_cmp++;
            if (bram[base + AL'(i)] !== words[i]) begin
                n_err++;
                $display("FAIL %s readback[%0d]: got %h want %h", name, base + AL'(i),
                         bram[base + AL'(i)], words[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; base_addr = '0; len = '0;
        #12;
        n_cmp++;
        if ({s_ready, ena, wea, flag_1per16, busy, done} !== 6'b0 || addra !== '0 || dia !== '0) begin
            n_err++;
            $display("FAIL reset_state: ctl=%b addra=%0d dia=%h want all zero",
                     {s_ready, ena, wea, flag_1per16, busy, done}, addra, dia);
        end
        exp_addra = '0; exp_dia = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill32();
        run_block(AL'(0), 32, 0, 1'b0, 1'b0, 0, "fill32");
    endtask

    task automatic test_gappy();
        run_block(AL'(100), 5, 1, 1'b0, 1'b0, 0, "gappy5");
    endtask

    task automatic test_wrap();
        run_block(AL'(8190), 4, 2, 1'b0, 1'b0, 0, "wrap4");
    endtask

    task automatic test_len0_full();
        run_block(AL'(0), 0, 0, 1'b0, 1'b1, 0, "len0");
    endtask

    task automatic test_reset_mid();
        run_block(AL'($urandom_range(0, 8191)), 64, 0, 1'b0, 1'b0, 10, "rst_mid");
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({s_ready, ena, wea, flag_1per16, busy, done} !== 6'b0 || addra !== '0 || dia !== '0) begin
            n_err++;
            $display("FAIL async_reset: ctl=%b addra=%0d dia=%h want all zero",
                     {s_ready, ena, wea, flag_1per16, busy, done}, addra, dia);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || wea !== 1'b0) begin
                n_err++; $display("FAIL reset_hold: done/wea=%b%b want 00", done, wea);
            end
        end
        rst = 1'b1;
        exp_addra = '0; exp_dia = '0;
        run_block(AL'(0), 16, 2, 1'b0, 1'b0, 0, "after_rst16");
    endtask

    task automatic test_random_blocks();
        run_block(AL'($urandom_range(0, 8191)), 600, 0, 1'b0, 1'b0, 0, "len_over");
        for (int b = 0; b < 4; b++) begin
            run_block(AL'($urandom_range(0, 8191)), $urandom_range(1, 80),
                      $urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)), 0, "rand");
        end
    endtask

    task automatic test_checksum();
        run_block(AL'(40), 16, 0, 1'b1, 1'b0, 0, "sum1to16");
        run_block(AL'(200), 17, 2, 1'b0, 1'b0, 0, "sum_next");
    endtask

    initial begin
        test_reset();
        test_fill32();
        test_gappy();
        test_wrap();
        test_len0_full();
        test_reset_mid();
        test_random_blocks();
        test_checksum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
